// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stage bit indices,
// hold/branch encodings, debug FSM states and the stall-vector helper.
// No ports; imported by pipe_ctrl and pipe_stall_wdt.
package pipe_ctrl_pkg;

  localparam int NUM_STG = 5;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;

  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  localparam logic BRANCH_ENABLE = 1'b1;

  // While draining/halted only PC and IF are frozen; ID/EX/MEM keep moving
  // so that the instructions already in flight retire as bubbles follow.
  localparam logic [NUM_STG-1:0] HALT_VEC = 5'b00011;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } dbg_state_t;

  // A stall in a stage must also hold every stage upstream of it.
  function automatic logic [NUM_STG-1:0] stall_vec_upto(input int stg);
    logic [NUM_STG-1:0] v;
    for (int i = 0; i < NUM_STG; i++) begin
      v[i] = (i <= stg) ? STOP : NO_STOP;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_stall_wdt.sv
// Stall watchdog: counts consecutive cycles with any stall request and
// raises a sticky timeout when the count reaches WDT_LIMIT (saturating).
// Ports: clk, rst (sync, active-high), stall_any in, timeout out (registered).
// Only compiled when STALL_WDT_EN is defined; otherwise this file is empty.
`ifdef STALL_WDT_EN
module pipe_stall_wdt
  import pipe_ctrl_pkg::*;
#(
  parameter int WDT_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_any,
  output logic timeout
);

  localparam int CW = $clog2(WDT_LIMIT + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (stall_any) begin
      cnt_next = (cnt == CW'(WDT_LIMIT)) ? cnt : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (cnt_next == CW'(WDT_LIMIT)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage hold vector, EX branch redirect (held while EX
// is frozen), and debug halt/resume with drain. Zero-cycle request->stall path.
// Ports: stallreq_* in, ex_branch_* in, halt/resume in; stalled_o, branch_*_o,
// halted_o, stall_timeout_o out. Optional watchdog under macro STALL_WDT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DRAIN_CYCLES = 3
`ifdef STALL_WDT_EN
  ,
  parameter int WDT_LIMIT    = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              ex_branch_flag_i,
  input  logic [ADDR_W-1:0] ex_branch_addr_i,
  input  logic              halt_req_i,
  input  logic              resume_req_i,
  output logic [4:0]        stalled_o,
  output logic              branch_flag_o,
  output logic [ADDR_W-1:0] branch_addr_o,
  output logic              halted_o,
  output logic              stall_timeout_o
);

  localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  dbg_state_t         state;
  logic [CNT_W-1:0]   drain_cnt;
  logic [CNT_W-1:0]   drain_next;
  logic               halted_q;
  logic               pend_v;
  logic [ADDR_W-1:0]  pend_addr;
  logic [NUM_STG-1:0] req_vec;
  logic [NUM_STG-1:0] halt_vec;
  logic               any_req;
  logic               ex_frozen;
  logic               drain_ok;

  assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

  // Highest (most downstream) requesting stage decides the hold vector.
  always_comb begin
    req_vec = '0;
    if (stallreq_mem)     req_vec = stall_vec_upto(STG_MEM);
    else if (stallreq_ex) req_vec = stall_vec_upto(STG_EX);
    else if (stallreq_id) req_vec = stall_vec_upto(STG_ID);
    else if (stallreq_if) req_vec = stall_vec_upto(STG_IF);
  end

  assign halt_vec  = (state == ST_DRAIN || state == ST_HALTED) ? HALT_VEC : '0;
  assign stalled_o = req_vec | halt_vec;
  assign ex_frozen = stalled_o[STG_EX];

  // A pending branch is older than anything currently in EX, so it takes
  // priority for both the flag and the target.
  assign branch_flag_o = (ex_branch_flag_i | pend_v) & ~ex_frozen;
  assign branch_addr_o = pend_v ? pend_addr : ex_branch_addr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
    end else if (branch_flag_o == BRANCH_ENABLE) begin
      pend_v <= 1'b0;
    end else if (ex_frozen && ex_branch_flag_i && !pend_v) begin
      pend_v    <= 1'b1;
      pend_addr <= ex_branch_addr_i;
    end
  end

  // A drain cycle only counts when nothing is stalled and no redirect is
  // still owed; otherwise the in-flight instructions have not advanced.
  assign drain_ok   = ~any_req & ~pend_v;
  assign drain_next = (drain_ok && drain_cnt != '0) ? drain_cnt - CNT_W'(1) : drain_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_req_i) begin
            state     <= ST_DRAIN;
            drain_cnt <= CNT_W'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_next;
          if (drain_next == '0) begin
            state    <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (resume_req_i) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted_o = halted_q;

`ifdef STALL_WDT_EN
  pipe_stall_wdt #(
    .WDT_LIMIT(WDT_LIMIT)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .stall_any(any_req),
    .timeout  (stall_timeout_o)
  );
`else
  assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
// Ports: none (top level). Watchdog cases run when STALL_WDT_EN is defined.
module tb_pipe_ctrl;

  localparam int WDT_LIM = 8;
  localparam int DRAIN   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sif, sid, sex, smem, br, halt, resume;
  logic [31:0] baddr_in;
  logic [4:0]  stalled;
  logic        bflag, halted, tmo;
  logic [31:0] baddr;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_mode;   // 0 run, 1 drain, 2 halted
  int          m_drain;
  logic [31:0] pq[$];
  int          m_wdt;
  bit          m_to;
  logic [4:0]  e_stalled;
  logic        e_bflag, e_halted, e_to;
  logic [31:0] e_baddr;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .ADDR_W(32),
    .DRAIN_CYCLES(DRAIN)
`ifdef STALL_WDT_EN
    ,
    .WDT_LIMIT(WDT_LIM)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_if     (sif),
    .stallreq_id     (sid),
    .stallreq_ex     (sex),
    .stallreq_mem    (smem),
    .ex_branch_flag_i(br),
    .ex_branch_addr_i(baddr_in),
    .halt_req_i      (halt),
    .resume_req_i    (resume),
    .stalled_o       (stalled),
    .branch_flag_o   (bflag),
    .branch_addr_o   (baddr),
    .halted_o        (halted),
    .stall_timeout_o (tmo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setin(input logic r, input logic i_f, input logic i_d, input logic i_e,
                       input logic i_m, input logic b, input logic [31:0] a,
                       input logic h, input logic rs);
    rst = r; sif = i_f; sid = i_d; sex = i_e; smem = i_m;
    br = b; baddr_in = a; halt = h; resume = rs;
    #3;
  endtask

  task automatic model_eval();
    logic [4:0] reqv;
    if (smem)      reqv = 5'b11111;
    else if (sex)  reqv = 5'b01111;
    else if (sid)  reqv = 5'b00111;
    else if (sif)  reqv = 5'b00011;
    else           reqv = 5'b00000;
    e_stalled = reqv | ((m_mode != 0) ? 5'b00011 : 5'b00000);
    e_bflag   = (br || pq.size() != 0) && !e_stalled[3];
    e_baddr   = (pq.size() != 0) ? pq[0] : baddr_in;
    e_halted  = (m_mode == 2);
    e_to      = m_to;
  endtask

  task automatic model_update();
    bit anyreq, clean;
    model_eval();
    if (rst) begin
      m_mode = 0; m_drain = 0; pq.delete(); m_wdt = 0; m_to = 0;
    end else begin
      anyreq = sif || sid || sex || smem;
      clean  = !anyreq && pq.size() == 0;
      if (e_bflag) pq.delete();
      else if (e_stalled[3] && br && pq.size() == 0) pq.push_back(baddr_in);
      case (m_mode)
        0: if (halt) begin m_mode = 1; m_drain = DRAIN; end
        1: begin
          if (clean && m_drain > 0) m_drain--;
          if (m_drain == 0) m_mode = 2;
        end
        default: if (resume) m_mode = 0;
      endcase
`ifdef STALL_WDT_EN
      if (anyreq) m_wdt = (m_wdt < WDT_LIM) ? m_wdt + 1 : WDT_LIM;
      else        m_wdt = 0;
      if (m_wdt >= WDT_LIM) m_to = 1;
`endif
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        i_f, i_d, i_e, i_m, b;
    logic [31:0] a;
    logic [4:0]  e_st;
    logic        e_bf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 32'h0,    5'b00011, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 32'h0,    5'b00111, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 32'h0,    5'b01111, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 32'h0,    5'b11111, 0};
    tbl[4]  = '{0, 1, 0, 1, 0, 32'h0,    5'b11111, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 32'h0,    5'b00111, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 32'h0,    5'b00000, 0};
    tbl[7]  = '{1, 0, 1, 0, 0, 32'h0,    5'b01111, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 32'h1234, 5'b00000, 1};
    tbl[9]  = '{0, 1, 0, 0, 1, 32'h55,   5'b00111, 1};
    tbl[10] = '{1, 0, 0, 0, 1, 32'h77,   5'b00011, 1};

    // reset
    @(posedge clk); #1;
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stalled", 32'(stalled), 0);
    chk("rst_bflag",   32'(bflag),   0);
    chk("rst_baddr",   baddr,        0);
    chk("rst_halted",  32'(halted),  0);
    chk("rst_tmo",     32'(tmo),     0);
    tick();

    // table vectors: stall priority and unhindered branches
    for (int k = 0; k < 11; k++) begin
      setin(0, tbl[k].i_f, tbl[k].i_d, tbl[k].i_e, tbl[k].i_m, tbl[k].b, tbl[k].a, 0, 0);
      chk($sformatf("tbl%0d_stalled", k), 32'(stalled), 32'(tbl[k].e_st));
      chk($sformatf("tbl%0d_bflag", k),   32'(bflag),   32'(tbl[k].e_bf));
      if (tbl[k].e_bf) chk($sformatf("tbl%0d_baddr", k), baddr, tbl[k].a);
      tick();
    end

    // branch resolved while MEM stalls EX
    setin(0, 0, 0, 0, 1, 0, 0, 0, 0);            chk("bst_c0_bflag", 32'(bflag), 0); tick();
    setin(0, 0, 0, 0, 1, 1, 32'h8000_0040, 0, 0); chk("bst_c1_bflag", 32'(bflag), 0); tick();
    setin(0, 0, 0, 0, 1, 0, 0, 0, 0);            chk("bst_c2_bflag", 32'(bflag), 0); tick();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bst_rel_bflag", 32'(bflag), 1);
    chk("bst_rel_baddr", baddr, 32'h8000_0040);
    tick();
    chk("bst_after_bflag", 32'(bflag), 0); tick();

    // competing branch while one is pending: older wins, single pulse
    setin(0, 0, 0, 1, 0, 1, 32'h100, 0, 0); chk("cmp_c0_bflag", 32'(bflag), 0); tick();
    setin(0, 0, 0, 1, 0, 1, 32'h200, 0, 0);
    chk("cmp_c1_bflag", 32'(bflag), 0);
    chk("cmp_c1_baddr", baddr, 32'h100);
    tick();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("cmp_rel_bflag", 32'(bflag), 1);
    chk("cmp_rel_baddr", baddr, 32'h100);
    tick();
    chk("cmp_after_bflag", 32'(bflag), 0); tick();

    // halt with no stalls, then simultaneous halt+resume while halted
    setin(0, 0, 0, 0, 0, 0, 0, 1, 0); chk("hlt_c0_stalled", 32'(stalled), 0); tick();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hlt_c1_stalled", 32'(stalled), 32'b00011);
    chk("hlt_c1_halted", 32'(halted), 0); tick();
    chk("hlt_c2_halted", 32'(halted), 0); tick();
    chk("hlt_c3_halted", 32'(halted), 0); tick();
    chk("hlt_c4_halted", 32'(halted), 1);
    chk("hlt_c4_stalled", 32'(stalled), 32'b00011); tick();
    setin(0, 0, 0, 0, 0, 0, 0, 1, 1); chk("hlt_c5_halted", 32'(halted), 1); tick();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("res_stalled", 32'(stalled), 0);
    chk("res_halted", 32'(halted), 0); tick();

    // halt delayed by exactly four EX-stalled cycles
    setin(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    for (int c = 1; c <= 4; c++) begin
      setin(0, 0, 0, 1, 0, 0, 0, 0, 0);
      if (c == 1) chk("hst_c1_stalled", 32'(stalled), 32'b01111);
      tick();
    end
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 5; c <= 7; c++) begin
      chk($sformatf("hst_c%0d_halted", c), 32'(halted), 0); tick();
    end
    chk("hst_c8_halted", 32'(halted), 1);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("hst_res_halted", 32'(halted), 0); tick();

    // reset drops a pending branch
    setin(0, 0, 0, 1, 0, 1, 32'hABC, 0, 0); tick();
    setin(1, 0, 0, 1, 0, 0, 0, 0, 0); tick();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rstp_bflag", 32'(bflag), 0);
    chk("rstp_baddr", baddr, 0);
    tick();

`ifdef STALL_WDT_EN
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int c = 0; c < WDT_LIM; c++) begin
      setin(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("wdt_c%0d_tmo", c), 32'(tmo), 0);
      tick();
    end
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("wdt_trip_tmo", 32'(tmo), 1); tick();
    chk("wdt_sticky_tmo", 32'(tmo), 1);
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("wdt_rst_tmo", 32'(tmo), 0); tick();
`endif

    // randomized traffic against the reference model
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int n = 0; n < 2000; n++) begin
      setin(($urandom_range(199) == 0),
            ($urandom_range(5) == 0), ($urandom_range(5) == 0),
            ($urandom_range(5) == 0), ($urandom_range(5) == 0),
            ($urandom_range(3) == 0), $urandom,
            ($urandom_range(19) == 0), ($urandom_range(7) == 0));
      model_eval();
      chk("rnd_stalled", 32'(stalled), 32'(e_stalled));
      chk("rnd_bflag",   32'(bflag),   32'(e_bflag));
      if (e_bflag) chk("rnd_baddr", baddr, e_baddr);
      chk("rnd_halted",  32'(halted),  32'(e_halted));
      chk("rnd_tmo",     32'(tmo),     32'(e_to));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
